// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES round-key buffer.
package aes_pkg;

    localparam int KEY_W     = 128;
    localparam int MAX_RK    = 15;
    localparam int NR_AES128 = 11;
    localparam int NR_AES256 = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

endpackage

// File: rtl/rk_regfile.sv
// Round-key flop array: one synchronous write port, one asynchronous read port.
module rk_regfile #(
    parameter int KEY_W = 128,
    parameter int DEPTH = 15
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic [3:0]       raddr,
    output logic [KEY_W-1:0] rdata
);

    logic [KEY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/key_round_store.sv
// Captures an expanded AES key schedule and replays it forward or reverse.
// The "type" select is named key_type since "type" is a SystemVerilog keyword.
module key_round_store
    import aes_pkg::*;
#(
    parameter int KEY_W  = aes_pkg::KEY_W,
    parameter int MAX_RK = aes_pkg::MAX_RK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             key_type,
    input  logic [KEY_W-1:0] rk_in,
    input  logic             rk_valid,
    output logic             ready,
    input  logic             rd_restart,
    input  logic             rd_dir,
    input  logic             rd_req,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_out_valid,
    output logic [3:0]       rk_idx,
    output logic             rd_last,
    output logic             rd_err
);

    state_e           state_q, state_d;
    logic [3:0]       nr_q, nr_d;
    logic [3:0]       wr_ptr_q, wr_ptr_d;
    logic [3:0]       rd_ptr_q, rd_ptr_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic [KEY_W-1:0] rk_out_q, rk_out_d;
    logic             valid_q, valid_d;
    logic [3:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic             wr_en;
    logic [3:0]       ptr_c;
    logic             dir_c;
    logic             done_c;
    logic             last_c;
    logic [3:0]       nr_m1;
    logic [3:0]       nr_sel;
    logic [KEY_W-1:0] rdata;

    rk_regfile #(
        .KEY_W(KEY_W),
        .DEPTH(MAX_RK)
    ) u_regfile (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr_q),
        .wdata(rk_in),
        .raddr(ptr_c),
        .rdata(rdata)
    );

    assign nr_m1  = nr_q - 4'd1;
    assign nr_sel = key_type ? 4'(NR_AES256) : 4'(NR_AES128);

    always_comb begin
        state_d  = state_q;
        nr_d     = nr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dir_d    = dir_q;
        done_d   = done_q;
        ready_d  = ready_q;
        rk_out_d = rk_out_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        ptr_c    = rd_ptr_q;
        dir_c    = dir_q;
        done_c   = done_q;
        last_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d  = LOAD;
                    nr_d     = nr_sel;
                    wr_ptr_d = 4'd0;
                end else if (rd_req) begin
                    err_d = 1'b1;
                end
            end
            LOAD: begin
                if (load_start) begin
                    nr_d     = nr_sel;
                    wr_ptr_d = 4'd0;
                end else begin
                    err_d = rd_req;
                    if (rk_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 4'd1;
                        if (wr_ptr_q == nr_m1) begin
                            state_d  = READY;
                            ready_d  = 1'b1;
                            rd_ptr_d = 4'd0;
                            dir_d    = 1'b0;
                            done_d   = 1'b0;
                        end
                    end
                end
            end
            READY: begin
                if (load_start) begin
                    state_d  = LOAD;
                    ready_d  = 1'b0;
                    nr_d     = nr_sel;
                    wr_ptr_d = 4'd0;
                end else begin
                    // Restart repositions first so a same-cycle read uses the new start.
                    if (rd_restart) begin
                        dir_c  = rd_dir;
                        ptr_c  = rd_dir ? nr_m1 : 4'd0;
                        done_c = 1'b0;
                    end
                    rd_ptr_d = ptr_c;
                    dir_d    = dir_c;
                    done_d   = done_c;
                    if (rd_req) begin
                        if (done_c) begin
                            err_d = 1'b1;
                        end else begin
                            last_c   = dir_c ? (ptr_c == 4'd0) : (ptr_c == nr_m1);
                            rk_out_d = rdata;
                            idx_d    = ptr_c;
                            valid_d  = 1'b1;
                            last_d   = last_c;
                            if (last_c) done_d = 1'b1;
                            else rd_ptr_d = dir_c ? ptr_c - 4'd1 : ptr_c + 4'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            nr_q     <= 4'(NR_AES128);
            wr_ptr_q <= 4'd0;
            rd_ptr_q <= 4'd0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            rk_out_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= 4'd0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nr_q     <= nr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            rk_out_q <= rk_out_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign ready        = ready_q;
    assign rk_out       = rk_out_q;
    assign rk_out_valid = valid_q;
    assign rk_idx       = idx_q;
    assign rd_last      = last_q;
    assign rd_err       = err_q;

endmodule
